// File: rtl/insn_encoder_pkg.sv
// ---------------------------------------------------------------------------
// insn_encoder_pkg
//
// Shared definitions for the RV32I instruction encoder:
//   cmd_op_t   - abstract command opcodes from the debug/boot controller
//   opcode_t   - RV32I major opcodes the encoder can produce
//   fmt_t      - instruction field layout selector for insn_pack
//   state_t    - encoder output FSM states
//   F3_*       - funct3 values the encoder needs to reason about
//   helpers    - illegal-command check and LI range check
// ---------------------------------------------------------------------------
package insn_encoder_pkg;

   typedef enum logic [2:0] {
      CMD_LI     = 3'd0,
      CMD_OPIMM  = 3'd1,
      CMD_OP     = 3'd2,
      CMD_LOAD   = 3'd3,
      CMD_STORE  = 3'd4,
      CMD_BRANCH = 3'd5,
      CMD_CSR    = 3'd6,
      CMD_EBREAK = 3'd7
   } cmd_op_t;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'h03,
      OPC_OPIMM  = 7'h13,
      OPC_STORE  = 7'h23,
      OPC_OP     = 7'h33,
      OPC_LUI    = 7'h37,
      OPC_BRANCH = 7'h63,
      OPC_SYSTEM = 7'h73
   } opcode_t;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4
   } fmt_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_EMIT      = 2'd1,
      ST_EMIT_PEND = 2'd2
   } state_t;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_PRIV = 3'b000;

   localparam logic [11:0] IMM_EBREAK = 12'h001;

   // A command is rejected when its funct3 has no RV32I meaning for that
   // class, or when the alternate funct7 bit is asked for on an ALU op that
   // has no alternate form (only SUB and SRA/SRAI exist).
   function automatic logic cmdIsIllegal(input cmd_op_t op,
                                         input logic [2:0] f3,
                                         input logic alt);
      logic bad;
      bad = 1'b0;
      case (op)
         CMD_OPIMM:  bad = alt && (f3 != F3_SR);
         CMD_OP:     bad = alt && (f3 != F3_ADD) && (f3 != F3_SR);
         CMD_LOAD:   bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         CMD_STORE:  bad = (f3 > 3'd2);
         CMD_BRANCH: bad = (f3 == 3'd2) || (f3 == 3'd3);
         CMD_CSR:    bad = (f3 == 3'd0) || (f3 == 3'd4);
         default:    bad = 1'b0;
      endcase
      return bad;
   endfunction

   // True when the value survives sign-extension from 12 bits, i.e. it lies
   // in [-2048, 2047] and a single ADDI can materialise it.
   function automatic logic liFitsAddi(input logic [31:0] imm);
      return (imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF);
   endfunction

endpackage

// File: rtl/insn_encoder_pack.sv
// ---------------------------------------------------------------------------
// insn_pack
//
// Purely combinational RV32I word formatter. Places already-decided fields
// into the bit positions of the selected format.
//   fmt_i    - fmt_t layout (R/I/S/B/U)
//   opcode_i - 7-bit major opcode
//   rd_i, rs1_i, rs2_i - register fields
//   f3_i     - funct3
//   f7_i     - funct7 (R-type only)
//   imm_i    - immediate; I/S use [11:0], B uses [12:1], U uses [31:12]
//   insn_o   - packed 32-bit instruction
// ---------------------------------------------------------------------------
module insn_pack
   import insn_encoder_pkg::*;
(
   input  logic [2:0]  fmt_i,
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  f3_i,
   input  logic [6:0]  f7_i,
   input  logic [31:0] imm_i,
   output logic [31:0] insn_o
);

   // Field placement per format. B-type drops imm[0] because branch targets
   // are always halfword aligned; U-type takes the upper 20 bits as-is.
   always_comb begin
      insn_o = 32'h0000_0000;
      case (fmt_t'(fmt_i))
         FMT_R: insn_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, opcode_i};
         FMT_I: insn_o = {imm_i[11:0], rs1_i, f3_i, rd_i, opcode_i};
         FMT_S: insn_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], opcode_i};
         FMT_B: insn_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
         FMT_U: insn_o = {imm_i[31:12], rd_i, opcode_i};
         default: insn_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/insn_encoder.sv
// ---------------------------------------------------------------------------
// insn_encoder
//
// Turns abstract commands from the debug/boot controller into one or two
// RV32I instruction words and streams them into the fetch-injection port.
//   clk_i, reset_i            - clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o - command handshake
//   cmd_op_i .. cmd_imm_i     - command payload (op, regs, funct3, alt, imm)
//   insn_valid_o / insn_ready_i - instruction word handshake
//   insn_o                    - registered instruction word
//   insn_last_o               - word is the final one of its command
//   err_o                     - one-cycle pulse when a command is rejected
//   count_o                   - words accepted by the consumer (wraps)
// ---------------------------------------------------------------------------
module insn_encoder
   import insn_encoder_pkg::*;
#(
   parameter int COUNT_W = 16
)
(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [2:0]         cmd_op_i,
   input  logic [4:0]         cmd_rd_i,
   input  logic [4:0]         cmd_rs1_i,
   input  logic [4:0]         cmd_rs2_i,
   input  logic [2:0]         cmd_f3_i,
   input  logic               cmd_alt_i,
   input  logic [31:0]        cmd_imm_i,
   output logic               insn_valid_o,
   input  logic               insn_ready_i,
   output logic [31:0]        insn_o,
   output logic               insn_last_o,
   output logic               err_o,
   output logic [COUNT_W-1:0] count_o
);

   state_t             state_q;
   logic               valid_q;
   logic [31:0]        insn_q;
   logic               last_q;
   logic [31:0]        pend_q;
   logic               err_q;
   logic [COUNT_W-1:0] count_q;

   cmd_op_t     cmdOp;
   logic        cmdIllegal;
   logic        cmdAccept;
   logic        insnFire;
   logic        twoWord;

   fmt_t        firstFmt;
   opcode_t     firstOpc;
   logic [4:0]  firstRd;
   logic [4:0]  firstRs1;
   logic [4:0]  firstRs2;
   logic [2:0]  firstF3;
   logic [6:0]  firstF7;
   logic [31:0] firstImm;
   logic [31:0] firstWord_d;

   logic [31:0] liHi;
   logic [11:0] liLo;
   logic [31:0] secondWord_d;

   assign cmdOp      = cmd_op_t'(cmd_op_i);
   assign cmdIllegal = cmdIsIllegal(cmdOp, cmd_f3_i, cmd_alt_i);

   // A new command can be taken when the output slot is empty, or when the
   // final word of the current command leaves this very cycle. The ready
   // path from the consumer is deliberately combinational so streaming runs
   // at one word per cycle; cmd_valid_i never feeds back into it.
   assign cmd_ready_o = !valid_q || (insn_ready_i && last_q);
   assign cmdAccept   = cmd_valid_i && cmd_ready_o;
   assign insnFire    = valid_q && insn_ready_i;

   // LUI/ADDI split: the +0x800 rounds hi up whenever lo will be negative
   // after ADDI sign-extends it, so LUI hi followed by ADDI lo rebuilds imm.
   assign liHi = cmd_imm_i + 32'h0000_0800;
   assign liLo = cmd_imm_i[11:0];

   // Decide the fields of the first (or only) word of the command, and
   // whether a second word is needed. Only LI ever needs two words.
   always_comb begin
      firstFmt = FMT_I;
      firstOpc = OPC_OPIMM;
      firstRd  = cmd_rd_i;
      firstRs1 = cmd_rs1_i;
      firstRs2 = cmd_rs2_i;
      firstF3  = cmd_f3_i;
      firstF7  = 7'b000_0000;
      firstImm = cmd_imm_i;
      twoWord  = 1'b0;
      case (cmdOp)
         CMD_LI: begin
            firstRs1 = 5'd0;
            firstF3  = F3_ADD;
            if (cmd_rd_i == 5'd0) begin
               // Writing x0 is a no-op; emit the canonical NOP.
               firstRd  = 5'd0;
               firstImm = 32'h0000_0000;
            end else if (!liFitsAddi(cmd_imm_i)) begin
               firstFmt = FMT_U;
               firstOpc = OPC_LUI;
               firstImm = {liHi[31:12], 12'h000};
               twoWord  = (liLo != 12'h000);
            end
         end
         CMD_OPIMM: begin
            // Shifts encode shamt in imm[4:0] and funct7 in imm[11:5]; the
            // alternate bit only means something for right shifts.
            if ((cmd_f3_i == F3_SLL) || (cmd_f3_i == F3_SR)) begin
               firstImm = {20'h00000, 1'b0, cmd_alt_i & cmd_f3_i[2], 5'b00000,
                           cmd_imm_i[4:0]};
            end
         end
         CMD_OP: begin
            firstFmt = FMT_R;
            firstOpc = OPC_OP;
            firstF7  = {1'b0, cmd_alt_i, 5'b00000};
         end
         CMD_LOAD: begin
            firstOpc = OPC_LOAD;
         end
         CMD_STORE: begin
            firstFmt = FMT_S;
            firstOpc = OPC_STORE;
         end
         CMD_BRANCH: begin
            firstFmt = FMT_B;
            firstOpc = OPC_BRANCH;
         end
         CMD_CSR: begin
            // For the immediate CSR forms the rs1 field carries the 5-bit
            // uimm, so cmd_rs1_i is passed straight through either way.
            firstOpc = OPC_SYSTEM;
            firstImm = {20'h00000, cmd_imm_i[11:0]};
         end
         CMD_EBREAK: begin
            firstOpc = OPC_SYSTEM;
            firstRd  = 5'd0;
            firstRs1 = 5'd0;
            firstF3  = F3_PRIV;
            firstImm = {20'h00000, IMM_EBREAK};
         end
         default: begin
            firstFmt = FMT_I;
         end
      endcase
   end

   insn_pack uFirstPack (
      .fmt_i    (firstFmt),
      .opcode_i (firstOpc),
      .rd_i     (firstRd),
      .rs1_i    (firstRs1),
      .rs2_i    (firstRs2),
      .f3_i     (firstF3),
      .f7_i     (firstF7),
      .imm_i    (firstImm),
      .insn_o   (firstWord_d)
   );

   // Second word of a split LI: ADDI rd, rd, lo.
   insn_pack uSecondPack (
      .fmt_i    (FMT_I),
      .opcode_i (OPC_OPIMM),
      .rd_i     (cmd_rd_i),
      .rs1_i    (cmd_rd_i),
      .rs2_i    (5'd0),
      .f3_i     (F3_ADD),
      .f7_i     (7'b000_0000),
      .imm_i    ({20'h00000, liLo}),
      .insn_o   (secondWord_d)
   );

   // Output FSM. IDLE and EMIT share the "may load a new command" path;
   // EMIT_PEND cannot take a command (last_q is low so cmd_ready_o is low)
   // and only advances when the consumer takes the LUI. Rejected commands
   // fall through as "no load", so a rejected command arriving while the
   // final word leaves simply drains the slot.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         insn_q  <= 32'h0000_0000;
         last_q  <= 1'b0;
         pend_q  <= 32'h0000_0000;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         err_q <= cmdAccept && cmdIllegal;
         if (insnFire) begin
            count_q <= count_q + COUNT_W'(1);
         end
         case (state_q)
            ST_IDLE, ST_EMIT: begin
               if (cmdAccept && !cmdIllegal) begin
                  valid_q <= 1'b1;
                  insn_q  <= firstWord_d;
                  last_q  <= !twoWord;
                  pend_q  <= secondWord_d;
                  state_q <= twoWord ? ST_EMIT_PEND : ST_EMIT;
               end else if (insnFire) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_EMIT_PEND: begin
               if (insnFire) begin
                  insn_q  <= pend_q;
                  last_q  <= 1'b1;
                  state_q <= ST_EMIT;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign insn_valid_o = valid_q;
   assign insn_o       = insn_q;
   assign insn_last_o  = last_q;
   assign err_o        = err_q;
   assign count_o      = count_q;

endmodule

// File: tb/tb_insn_encoder.sv
// ---------------------------------------------------------------------------
// tb_insn_encoder
//
// Scoreboard bench for insn_encoder: expected words are queued when each
// command is driven and popped by a monitor whenever a word is accepted.
// ---------------------------------------------------------------------------
module tb_insn_encoder;

   localparam int COUNT_W = 16;

   localparam logic [2:0] OP_LI     = 3'd0;
   localparam logic [2:0] OP_OPIMM  = 3'd1;
   localparam logic [2:0] OP_OP     = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_STORE  = 3'd4;
   localparam logic [2:0] OP_BRANCH = 3'd5;
   localparam logic [2:0] OP_CSR    = 3'd6;
   localparam logic [2:0] OP_EBREAK = 3'd7;

   logic               clk_i = 1'b0;
   logic               reset_i = 1'b1;
   logic               cmd_valid_i = 1'b0;
   logic               cmd_ready_o;
   logic [2:0]         cmd_op_i = 3'd0;
   logic [4:0]         cmd_rd_i = 5'd0;
   logic [4:0]         cmd_rs1_i = 5'd0;
   logic [4:0]         cmd_rs2_i = 5'd0;
   logic [2:0]         cmd_f3_i = 3'd0;
   logic               cmd_alt_i = 1'b0;
   logic [31:0]        cmd_imm_i = 32'd0;
   logic               insn_valid_o;
   logic               insn_ready_i = 1'b1;
   logic [31:0]        insn_o;
   logic               insn_last_o;
   logic               err_o;
   logic [COUNT_W-1:0] count_o;

   typedef struct {
      logic [31:0] word;
      logic        last;
   } exp_t;

   exp_t expQ[$];
   exp_t popped;
   int   fireLog[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   insn_encoder #(.COUNT_W(COUNT_W)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_op_i     (cmd_op_i),
      .cmd_rd_i     (cmd_rd_i),
      .cmd_rs1_i    (cmd_rs1_i),
      .cmd_rs2_i    (cmd_rs2_i),
      .cmd_f3_i     (cmd_f3_i),
      .cmd_alt_i    (cmd_alt_i),
      .cmd_imm_i    (cmd_imm_i),
      .insn_valid_o (insn_valid_o),
      .insn_ready_i (insn_ready_i),
      .insn_o       (insn_o),
      .insn_last_o  (insn_last_o),
      .err_o        (err_o),
      .count_o      (count_o)
   );

   // 10 ns clock.
   always #5 clk_i = ~clk_i;

   // Cycle counter used to prove back-to-back words land in adjacent cycles.
   always @(posedge clk_i) cyc <= cyc + 1;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic expectWord(input logic [31:0] word, input logic last);
      exp_t e;
      e.word = word;
      e.last = last;
      expQ.push_back(e);
   endtask

   // Drive one command and hold it until the encoder takes it. Returns one
   // time step after the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic alt,
                                input logic [31:0] imm);
      bit accepted;
      cmd_op_i    = op;
      cmd_rd_i    = rd;
      cmd_rs1_i   = rs1;
      cmd_rs2_i   = rs2;
      cmd_f3_i    = f3;
      cmd_alt_i   = alt;
      cmd_imm_i   = imm;
      cmd_valid_i = 1'b1;
      accepted    = 1'b0;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge clk_i);
         if (cmd_ready_o) accepted = 1'b1;
      end
      if (!accepted) checkOutput("cmdTimeout", {31'd0, cmd_ready_o}, 32'd1);
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
   endtask

   // Wait (bounded) until the output slot drains, then step past the edge.
   task automatic waitIdle();
      @(negedge clk_i);
      for (int i = 0; i < 100 && insn_valid_o; i++) @(negedge clk_i);
      if (insn_valid_o) checkOutput("idleTimeout", {31'd0, insn_valid_o}, 32'd0);
      @(posedge clk_i);
      #1;
   endtask

   // Scoreboard monitor: compare every accepted word against the queue head.
   always @(negedge clk_i) begin
      if (!reset_i && insn_valid_o && insn_ready_i) begin
         if (expQ.size() == 0) begin
            checkOutput("sbUnderflow", 32'(expQ.size()), 32'd1);
         end else begin
            popped = expQ.pop_front();
            checkOutput("word", insn_o, popped.word);
            checkOutput("last", {31'd0, insn_last_o}, {31'd0, popped.last});
         end
         fireLog.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [2:0] badOp[3];
      logic [2:0] badF3[3];
      logic       badAlt[3];
      logic [31:0] im;
      logic [31:0] wd;

      // Reset values.
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("rstValid", {31'd0, insn_valid_o}, 32'd0);
      checkOutput("rstInsn", insn_o, 32'd0);
      checkOutput("rstLast", {31'd0, insn_last_o}, 32'd0);
      checkOutput("rstErr", {31'd0, err_o}, 32'd0);
      checkOutput("rstCount", 32'(count_o), 32'd0);
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      @(negedge clk_i);
      checkOutput("readyAfterRst", {31'd0, cmd_ready_o}, 32'd1);
      @(posedge clk_i);
      #1;

      // LI variants and the fixed encodings from the plan.
      expectWord(32'h123452B7, 1'b0);
      expectWord(32'h67828293, 1'b1);
      applyStimulus(OP_LI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345678);
      expectWord(32'h80000093, 1'b1);
      applyStimulus(OP_LI, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF800);
      expectWord(32'h00001137, 1'b0);
      expectWord(32'h80010113, 1'b1);
      applyStimulus(OP_LI, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000800);
      expectWord(32'h000101B7, 1'b1);
      applyStimulus(OP_LI, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00010000);
      expectWord(32'h00000013, 1'b1);
      applyStimulus(OP_LI, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345678);
      expectWord(32'h0063A423, 1'b1);
      applyStimulus(OP_STORE, 5'd0, 5'd7, 5'd6, 3'd2, 1'b0, 32'd8);
      expectWord(32'h00100073, 1'b1);
      applyStimulus(OP_EBREAK, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
      expectWord(32'h403100B3, 1'b1);
      applyStimulus(OP_OP, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'd0);
      expectWord(32'h4032D213, 1'b1);
      applyStimulus(OP_OPIMM, 5'd4, 5'd5, 5'd0, 3'd5, 1'b1, 32'd3);
      expectWord(32'h00209463, 1'b1);
      applyStimulus(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 1'b0, 32'd8);
      expectWord(32'h30002573, 1'b1);
      applyStimulus(OP_CSR, 5'd10, 5'd0, 5'd0, 3'd2, 1'b0, 32'h00000300);
      expectWord(32'h0044A403, 1'b1);
      applyStimulus(OP_LOAD, 5'd8, 5'd9, 5'd0, 3'd2, 1'b0, 32'd4);
      waitIdle();

      // Illegal commands: one-cycle err pulse, nothing emitted.
      badOp[0] = OP_LOAD;   badF3[0] = 3'd3; badAlt[0] = 1'b0;
      badOp[1] = OP_BRANCH; badF3[1] = 3'd2; badAlt[1] = 1'b0;
      badOp[2] = OP_OP;     badF3[2] = 3'd1; badAlt[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(badOp[k], 5'd1, 5'd2, 5'd3, badF3[k], badAlt[k], 32'd0);
         @(negedge clk_i);
         checkOutput("errPulse", {31'd0, err_o}, 32'd1);
         checkOutput("errNoValid", {31'd0, insn_valid_o}, 32'd0);
         @(negedge clk_i);
         checkOutput("errCleared", {31'd0, err_o}, 32'd0);
         checkOutput("errStillIdle", {31'd0, insn_valid_o}, 32'd0);
         @(posedge clk_i);
         #1;
      end

      // Reset, then stream 8 ADDI commands back to back.
      reset_i = 1'b1;
      expQ.delete();
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      fireLog.delete();
      for (int i = 0; i < 8; i++) begin
         im = 32'(i * 37) - 32'd100;
         wd = {im[11:0], 5'd0, 3'd0, 5'(i + 1), 7'h13};
         expectWord(wd, 1'b1);
         applyStimulus(OP_OPIMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 1'b0, im);
      end
      waitIdle();
      checkOutput("streamCount", 32'(count_o), 32'd8);
      checkOutput("streamFires", 32'(fireLog.size()), 32'd8);
      if (fireLog.size() >= 8)
         checkOutput("streamSpan", 32'(fireLog[7] - fireLog[0]), 32'd7);

      // Backpressure during a two-word LI.
      insn_ready_i = 1'b0;
      expectWord(32'h123452B7, 1'b0);
      expectWord(32'h67828293, 1'b1);
      applyStimulus(OP_LI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345678);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         checkOutput("bpValid", {31'd0, insn_valid_o}, 32'd1);
         checkOutput("bpInsn", insn_o, 32'h123452B7);
         checkOutput("bpLast", {31'd0, insn_last_o}, 32'd0);
         checkOutput("bpCount", 32'(count_o), 32'd8);
         checkOutput("bpCmdReady", {31'd0, cmd_ready_o}, 32'd0);
      end
      @(posedge clk_i);
      #1 insn_ready_i = 1'b1;
      waitIdle();
      checkOutput("bpCountAfter", 32'(count_o), 32'd10);

      // Reset while the ADDI half of a split LI is on the output.
      expectWord(32'h123452B7, 1'b0);
      expectWord(32'h67828293, 1'b1);
      applyStimulus(OP_LI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345678);
      @(posedge clk_i);
      #1;
      checkOutput("pendVisible", insn_o, 32'h67828293);
      reset_i = 1'b1;
      insn_ready_i = 1'b0;
      expQ.delete();
      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("midRstValid", {31'd0, insn_valid_o}, 32'd0);
      checkOutput("midRstCount", 32'(count_o), 32'd0);
      checkOutput("midRstInsn", insn_o, 32'd0);
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      insn_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         checkOutput("noAddiAfterRst", {31'd0, insn_valid_o}, 32'd0);
      end

      checkOutput("sbDrain", 32'(expQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/insn_encoder.md
# insn_encoder

Command-driven RV32I instruction encoder, the producer-side counterpart of the CPU instruction decoder. It accepts abstract operation commands (register-immediate load, ALU ops, loads, stores, branches, CSR accesses, ebreak) from the debug/boot controller. It packs each command into one or two legal 32-bit instruction words and streams them, with a valid/ready handshake, into the fetch-injection port ahead of the decoder.

## Interface
Parameters:
- COUNT_W, 16, width of emitted-instruction counter

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i
- cmd_op_i  in  3  cmd_op_t: LI=0, OPIMM=1, OP=2, LOAD=3, STORE=4, BRANCH=5, CSR=6, EBREAK=7
- cmd_rd_i  in  5  destination register
- cmd_rs1_i  in  5  source register 1
- cmd_rs2_i  in  5  source register 2
- cmd_f3_i  in  3  funct3 (ALU op, access size, branch condition, CSR op)
- cmd_alt_i  in  1  funct7[5] for OP and shift OPIMM (SUB/SRA)
- cmd_imm_i  in  32  immediate / offset / CSR address in [11:0]
- insn_valid_o  out  1  instruction word valid
- insn_ready_i  in  1  consumer accepts word
- insn_o  out  32  encoded instruction
- insn_last_o  out  1  word is final word of its command
- err_o  out  1  one-cycle pulse: illegal command rejected
- count_o  out  COUNT_W  instructions accepted by consumer, wraps

## Operation
- FSM states: IDLE (output empty), EMIT (one word held), EMIT_PEND (first of two held, second queued).
- Encodings: OPIMM I-type, imm[11:0]; shift OPIMM (f3=001/101) uses imm[4:0], funct7 = {1'b0, cmd_alt_i & f3[2], 5'b0}. OP R-type, funct7[5]=cmd_alt_i. LOAD I-type opcode LOAD. STORE S-type. BRANCH B-type from imm[12:1], imm[0] ignored. CSR I-type, imm[11:0]=CSR address, rs1 field carries uimm for f3[2]=1. EBREAK emits 0x00100073.
- LI rd, imm:
  - imm in [-2048, 2047]: single ADDI rd, x0, imm[11:0].
  - Otherwise hi = (imm + 0x800) >> 12 (32-bit wrap), lo = imm[11:0]. Emit LUI rd, hi[19:0], then ADDI rd, rd, lo if lo != 0; if lo == 0, LUI alone.
  - rd == x0: single NOP 0x00000013.
- Illegal commands: LOAD f3 ∈ {3,6,7}; STORE f3 > 2; BRANCH f3 ∈ {2,3}; CSR f3 ∈ {0,4}; OPIMM/OP with cmd_alt_i=1 on f3 other than 000 (OP only) or 101.
  - Command is consumed, err_o pulses next cycle, nothing emitted, state stays IDLE.
- insn_last_o = 0 only on LUI of a two-word LI.
- count_o increments on every insn_valid_o && insn_ready_i.

## Timing
- Reset values: insn_valid_o=0, insn_o=0, insn_last_o=0, err_o=0, count_o=0, state IDLE. cmd_ready_o=1 the cycle after reset deasserts.
- cmd_ready_o = !insn_valid_o || (insn_ready_i && insn_last_o). Combinational path insn_ready_i → cmd_ready_o is intended; no path from cmd_valid_i.
- Latency: word appears on insn_o the cycle after command acceptance (registered output).
- Second LI word appears the cycle after the first is accepted.
- Back-to-back commands sustain one word per cycle.
- While insn_valid_o && !insn_ready_i, insn_o and insn_last_o hold stable.
- Simultaneous final-word acceptance and new command: new word loads same edge, insn_valid_o stays high.
- Reset mid-command: next cycle outputs at reset values, queued second word discarded, count_o cleared.

## Structure
- cpu_common: add cmd_op_t enum; reuse existing opcode_t and F3_* constants.
- Sub-module insn_pack: purely combinational formatter (R/I/S/B/U fields → word). It is instantiated twice: current word and queued second word.
- Top holds FSM, second-word register, counter, err pulse.

## Test plan
- LI x5, 0x12345678 → 0x123452B7 (last=0), then 0x67828293 (last=1).
- LI x1, 0xFFFFF800 → single 0x80000093. LI x2, 0x00000800 → 0x00001137 then 0x80010113. LI x3, 0x00010000 → single 0x000101B7.
- STORE f3=2, rs2=x6, rs1=x7, imm=8 → 0x0063A423. EBREAK → 0x00100073. LOAD f3=3 → err_o pulse, no insn_valid_o.
- Backpressure: insn_ready_i low 3 cycles during two-word LI → word stable, count_o unchanged. Streaming 8 ADDI commands with ready=1 → 8 words in 8 consecutive cycles, count_o=8.
- Reset asserted after LUI accepted, ADDI pending → next cycle insn_valid_o=0, count_o=0, ADDI never emitted.
